mcl_axil_pkt_tx: RTL

//  Host-to-manycore transmit path. Assembles 32-bit AXI-Lite data writes into

---
 rtl/cl_mcl_pkg.sv | 31 +++
 rtl/mcl_pkt_fifo.sv | 62 ++++++
 rtl/mcl_axil_pkt_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cl_mcl_pkg.sv
// Shared MCL host-link definitions: register offsets, AXI-Lite response codes,
// FSM state types and the 128-bit manycore request layout.
// Definitions only; no timing or flow-control behaviour of its own.
package cl_mcl_pkg;

    localparam logic [7:0] mcl_tx_data_ofs_p    = 8'h00;
    localparam logic [7:0] mcl_tx_vacancy_ofs_p = 8'h00;
    localparam logic [7:0] mcl_tx_credit_ofs_p  = 8'h04;
    localparam logic [7:0] mcl_tx_idx_ofs_p     = 8'h08;

    localparam logic [1:0] axil_resp_okay   = 2'b00;
    localparam logic [1:0] axil_resp_slverr = 2'b10;

    typedef enum logic {W_IDLE, W_BRESP} w_state_e;
    typedef enum logic {R_IDLE, R_RRESP} r_state_e;

    // Field layout of the classic 128-bit request; word 0 is the payload.
    typedef struct packed {
        logic [15:0] y_src;
        logic [15:0] x_src;
        logic [15:0] y_dst;
        logic [15:0] x_dst;
        logic [7:0]  reg_id;
        logic [7:0]  op;
        logic [15:0] addr;
        logic [31:0] payload;
    } bsg_mcl_request_s;

    localparam int mcl_request_width_gp = $bits(bsg_mcl_request_s);

endpackage

// File: rtl/mcl_pkt_fifo.sv
// Circular packet buffer, one write and one read port, occupancy exported.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: pushes are ignored while full; head pops on v_o & ready_i.
module mcl_pkt_fifo #(
    parameter int width_p = 128,
    parameter int els_p   = 16,
    localparam int cnt_w_lp = $clog2(els_p + 1),
    localparam int ptr_w_lp = $clog2(els_p)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                v_i,
    input  logic [width_p-1:0]  data_i,
    output logic                v_o,
    output logic [width_p-1:0]  data_o,
    input  logic                ready_i,
    output logic                full_o,
    output logic [cnt_w_lp-1:0] count_o
);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wr_ptr_q, rd_ptr_q;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push, pop;

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign push    = v_i & ~full_o;
    assign pop     = v_o & ready_i;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mcl_axil_pkt_tx.sv
// Host-to-manycore TX: AXI-Lite words assembled into packets, queued, sent on credits.
// Latency: B/R one cycle after accept; packet offered the cycle after its last word.
// Backpressure: last-word write stalls while FIFO full; dispatch gated by credits != 0.
module mcl_axil_pkt_tx
    import cl_mcl_pkg::*;
#(
    parameter int packet_width_p    = 128,
    parameter int fifo_els_p        = 16,
    parameter int max_credits_p     = 32,
    parameter int axil_addr_width_p = 32
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         s_awvalid_i,
    output logic                         s_awready_o,
    input  logic [axil_addr_width_p-1:0] s_awaddr_i,
    input  logic                         s_wvalid_i,
    output logic                         s_wready_o,
    input  logic [31:0]                  s_wdata_i,
    input  logic [3:0]                   s_wstrb_i,
    output logic                         s_bvalid_o,
    input  logic                         s_bready_i,
    output logic [1:0]                   s_bresp_o,
    input  logic                         s_arvalid_i,
    output logic                         s_arready_o,
    input  logic [axil_addr_width_p-1:0] s_araddr_i,
    output logic                         s_rvalid_o,
    input  logic                         s_rready_i,
    output logic [31:0]                  s_rdata_o,
    output logic [1:0]                   s_rresp_o,
    output logic                         pkt_v_o,
    output logic [packet_width_p-1:0]    pkt_o,
    input  logic                         pkt_ready_i,
    input  logic                         credit_return_i,
    output logic                         credit_err_o
);

    localparam int words_lp  = packet_width_p / 32;
    localparam int idx_w_lp  = $clog2(words_lp);
    localparam int vac_w_lp  = $clog2(fifo_els_p + 1);
    localparam int cred_w_lp = $clog2(max_credits_p + 1);

    w_state_e                w_state_q, w_state_d;
    r_state_e                r_state_q, r_state_d;
    logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [idx_w_lp-1:0]     idx_q, idx_d;
    logic [packet_width_p-1:0] slots_q, slots_d;
    logic [cred_w_lp-1:0]    credits_q, credits_d;
    logic                    err_q, err_d;

    logic                    w_acc, r_acc, wr_data_hit, idx_last;
    logic                    fifo_push, fifo_v, fifo_full, pkt_pop;
    logic [packet_width_p-1:0] fifo_wdata;
    logic [vac_w_lp-1:0]     fifo_count, vacancy;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^{s_wstrb_i, s_awaddr_i[axil_addr_width_p-1:8],
                                s_araddr_i[axil_addr_width_p-1:8]};

    assign wr_data_hit = (s_awaddr_i[7:0] == mcl_tx_data_ofs_p);
    assign idx_last    = (idx_q == idx_w_lp'(words_lp - 1));
    // Full FIFO stalls only the word that would complete a packet.
    assign w_acc       = ~reset_i & (w_state_q == W_IDLE) & s_awvalid_i & s_wvalid_i
                         & (~idx_last | ~fifo_full);
    assign r_acc       = ~reset_i & (r_state_q == R_IDLE) & s_arvalid_i;
    assign fifo_push   = w_acc & wr_data_hit & idx_last;
    assign fifo_wdata  = {s_wdata_i, slots_q[packet_width_p-33:0]};
    assign vacancy     = vac_w_lp'(fifo_els_p) - fifo_count;
    assign pkt_v_o     = fifo_v & (credits_q != '0);
    assign pkt_pop     = pkt_v_o & pkt_ready_i;
    assign credit_err_o = err_q;

    mcl_pkt_fifo #(
        .width_p (packet_width_p),
        .els_p   (fifo_els_p)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (fifo_push),
        .data_i  (fifo_wdata),
        .v_o     (fifo_v),
        .data_o  (pkt_o),
        .ready_i (pkt_pop),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        r_state_d = r_state_q;
        case (w_state_q)
            W_IDLE:  if (w_acc) w_state_d = W_BRESP;
            default: if (s_bready_i) w_state_d = W_IDLE;
        endcase
        case (r_state_q)
            R_IDLE:  if (r_acc) r_state_d = R_RRESP;
            default: if (s_rready_i) r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_awready_o = w_acc;
        s_wready_o  = w_acc;
        s_bvalid_o  = (w_state_q == W_BRESP);
        s_bresp_o   = bresp_q;
        s_arready_o = r_acc;
        s_rvalid_o  = (r_state_q == R_RRESP);
        s_rdata_o   = rdata_q;
        s_rresp_o   = rresp_q;
    end

    always_comb begin
        bresp_d = bresp_q;
        idx_d   = idx_q;
        slots_d = slots_q;
        if (w_acc) begin
            if (wr_data_hit) begin
                bresp_d = axil_resp_okay;
                slots_d[idx_q*32 +: 32] = s_wdata_i;
                idx_d = idx_last ? '0 : idx_q + 1'b1;
            end else begin
                bresp_d = axil_resp_slverr;
            end
        end
    end

    // Status is captured at AR acceptance, not at R delivery.
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (r_acc) begin
            rresp_d = axil_resp_okay;
            case (s_araddr_i[7:0])
                mcl_tx_vacancy_ofs_p: rdata_d = 32'(vacancy);
                mcl_tx_credit_ofs_p:  rdata_d = 32'(credits_q);
                mcl_tx_idx_ofs_p:     rdata_d = 32'(idx_q);
                default: begin
                    rdata_d = '0;
                    rresp_d = axil_resp_slverr;
                end
            endcase
        end
    end

    always_comb begin
        credits_d = credits_q;
        err_d     = err_q;
        case ({pkt_pop, credit_return_i})
            2'b10: credits_d = credits_q - 1'b1;
            2'b01: begin
                if (credits_q == cred_w_lp'(max_credits_p)) err_d = 1'b1;
                else credits_d = credits_q + 1'b1;
            end
            default: credits_d = credits_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bresp_q   <= axil_resp_okay;
            rresp_q   <= axil_resp_okay;
            rdata_q   <= '0;
            idx_q     <= '0;
            slots_q   <= '0;
            credits_q <= cred_w_lp'(max_credits_p);
            err_q     <= 1'b0;
        end else begin
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            slots_q   <= slots_d;
            credits_q <= credits_d;
            err_q     <= err_d;
        end
    end

endmodule
